// File: rtl/mfp_ahb_uart_transmitter.sv
// AHB-Lite UART transmitter: 16-entry byte FIFO fed through TXDATA, drained by an 8N1 serializer.
// State | meaning: IDLE line high, wait for FIFO data | START start bit | DATA 8 data bits LSB first | STOP stop bit
`timescale 1ns/1ps
module mfp_ahb_uart_transmitter #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int FIFO_AW   = 4
) (
    input  logic        HCLK,
    input  logic        SI_Reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        UART_TX
);

    localparam int DIV_RAW = CLK_FREQ / BAUD_RATE;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int BCW     = $clog2(DIV);
    localparam int DEPTH   = 1 << FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic               accept;
    logic               wr_q;
    logic               rd_q;
    logic [1:0]         offset_q;
    logic               push_req;
    logic               push_ok;
    logic               ovf_clr;
    logic               pop;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               empty;
    logic               ovf;
    logic               busy;

    state_t             state;
    state_t             state_nxt;
    logic [BCW-1:0]     bc;
    logic [BCW-1:0]     bc_d;
    logic [2:0]         bi;
    logic [2:0]         bi_d;
    logic [7:0]         sh;
    logic [7:0]         sh_d;
    logic               tx_q;
    logic               tx_d;
    logic               bit_end;

    logic               unused_ok;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign UART_TX   = tx_q;
    assign unused_ok = &{1'b0, HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:8]};

    // Address phase capture; the registers clear on any cycle without an accepted transfer.
    assign accept = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            offset_q <= 2'b00;
        end else begin
            wr_q     <= accept & HWRITE;
            rd_q     <= accept & ~HWRITE;
            offset_q <= accept ? HADDR[3:2] : 2'b00;
        end
    end

    assign push_req = wr_q && (offset_q == 2'd0);
    assign ovf_clr  = wr_q && (offset_q == 2'd1) && HWDATA[4];
    assign full     = count[FIFO_AW];
    assign empty    = (count == '0);
    assign push_ok  = push_req && !full;
    assign busy     = (state != S_IDLE) || !empty;

    always_comb begin
        HRDATA = 32'h0;
        if (rd_q && (offset_q == 2'd1))
            HRDATA = {27'b0, ovf, busy, 1'b0, empty, full};
    end

    always_ff @(posedge HCLK) begin
        if (push_ok)
            mem[wptr] <= HWDATA[7:0];
    end

    // A push into a full FIFO is dropped even when a pop frees a slot in the same cycle.
    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    assign bit_end = (bc == BCW'(DIV - 1));

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            state <= S_IDLE;
            bc    <= '0;
            bi    <= '0;
            sh    <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            bc    <= bc_d;
            bi    <= bi_d;
            sh    <= sh_d;
            tx_q  <= tx_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty) state_nxt = S_START;
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA:  if (bit_end && (bi == 3'd7)) state_nxt = S_STOP;
            S_STOP:  if (bit_end) state_nxt = empty ? S_IDLE : S_START;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The line level is computed from the next state so UART_TX comes straight off a flop.
    always_comb begin
        pop  = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
        bc_d = ((state == S_IDLE) || bit_end) ? '0 : bc + 1'b1;
        bi_d = bi;
        sh_d = sh;
        if (pop) begin
            sh_d = mem[rptr];
            bi_d = '0;
        end else if ((state == S_DATA) && bit_end) begin
            sh_d = {1'b0, sh[7:1]};
            bi_d = bi + 1'b1;
        end
        case (state_nxt)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mfp_ahb_uart_transmitter.sv
// Directed bench for mfp_ahb_uart_transmitter at DIV=10: timing, framing, FIFO overflow, status and reset.
`timescale 1ns/1ps
module tb_mfp_ahb_uart_transmitter;

    logic        HCLK = 1'b0;
    logic        SI_Reset;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        UART_TX;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  wbuf [0:31];
    logic [31:0] rd;

    mfp_ahb_uart_transmitter #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100),
        .FIFO_AW   (4)
    ) dut (
        .HCLK      (HCLK),
        .SI_Reset  (SI_Reset),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .UART_TX   (UART_TX)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // All bus tasks are entered and left just after a falling edge.
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic write_seq(input int n);
        for (int i = 0; i < n; i++) begin
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
            if (i > 0) HWDATA = {24'h0, wbuf[i-1]};
            @(negedge HCLK);
        end
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = {24'h0, wbuf[n-1]};
    endtask

    // Checks 100 cycles starting in the current cycle: 10 low, 8x10 data LSB first, 10 high.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic e;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge HCLK);
            if (k < 10)      e = 1'b0;
            else if (k < 90) e = b[(k - 10) / 10];
            else             e = 1'b1;
            chk(tag, {31'h0, UART_TX}, {31'h0, e});
        end
    endtask

    initial begin
        SI_Reset = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = 32'h0; HREADY = 1'b1;
        repeat (3) @(negedge HCLK);
        SI_Reset = 1'b0;

        chk("rst_tx", {31'h0, UART_TX}, 32'h1);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);

        ahb_read(32'h4, rd);  chk("status_reset", rd, 32'h02);
        ahb_read(32'h0, rd);  chk("read_off0", rd, 32'h0);
        ahb_read(32'h8, rd);  chk("read_off2", rd, 32'h0);
        ahb_read(32'hC, rd);  chk("read_off3", rd, 32'h0);

        HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0; HWDATA = 32'h77;
        repeat (3) @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b00;
        repeat (3) @(negedge HCLK);
        HSEL = 1'b0; HWRITE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            chk("idle_traffic_tx", {31'h0, UART_TX}, 32'h1);
        end
        ahb_read(32'h4, rd);  chk("idle_traffic_status", rd, 32'h02);

        ahb_write(32'h0, 32'h55);
        @(negedge HCLK);
        chk("single_tx_n1", {31'h0, UART_TX}, 32'h1);
        @(negedge HCLK);
        check_frame(8'h55, "single_55");
        ahb_read(32'h4, rd);  chk("single_busy_clear", rd, 32'h02);

        ahb_write(32'h0, 32'h3C);
        ahb_read(32'h4, rd);  chk("status_busy", rd, 32'h08);
        repeat (100) @(negedge HCLK);
        ahb_read(32'h4, rd);  chk("status_after_3c", rd, 32'h02);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h0F; wbuf[2] = 8'hFF;
        write_seq(3);
        check_frame(8'hA5, "b2b_a5");
        @(negedge HCLK);
        check_frame(8'h0F, "b2b_0f");
        @(negedge HCLK);
        check_frame(8'hFF, "b2b_ff");
        ahb_read(32'h4, rd);  chk("b2b_status_end", rd, 32'h02);
        chk("b2b_tx_idle", {31'h0, UART_TX}, 32'h1);

        for (int i = 0; i < 18; i++) wbuf[i] = 8'(i);
        write_seq(18);
        ahb_read(32'h4, rd);  chk("ovf_status", rd, 32'h19);
        ahb_write(32'h4, 32'h10);
        ahb_read(32'h4, rd);  chk("ovf_cleared", rd, 32'h09);
        repeat (81) @(negedge HCLK);
        for (int i = 1; i <= 16; i++) begin
            @(negedge HCLK);
            check_frame(8'(i), "ovf_frame");
        end
        for (int i = 0; i < 150; i++) begin
            @(negedge HCLK);
            chk("ovf_no_0x11", {31'h0, UART_TX}, 32'h1);
        end
        ahb_read(32'h4, rd);  chk("ovf_status_end", rd, 32'h02);

        wbuf[0] = 8'h96; wbuf[1] = 8'h11; wbuf[2] = 8'h22; wbuf[3] = 8'h33;
        write_seq(4);
        repeat (43) @(negedge HCLK);
        chk("midframe_bit3_low", {31'h0, UART_TX}, 32'h0);
        SI_Reset = 1'b1;
        @(negedge HCLK);
        SI_Reset = 1'b0;
        chk("midframe_rst_tx", {31'h0, UART_TX}, 32'h1);
        for (int i = 0; i < 300; i++) begin
            @(negedge HCLK);
            chk("midframe_stays_high", {31'h0, UART_TX}, 32'h1);
        end
        ahb_read(32'h4, rd);  chk("midframe_status", rd, 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_uart_transmitter.md
# mfp_ahb_uart_transmitter

AHB-Lite slave peripheral that transmits bytes on the board UART TX pin as 8N1 serial frames. The CPU writes bytes into a 16-entry FIFO through a data register, and a baud-rate serializer drains the FIFO. Status is readable through a second register. It sits on the AHB-Lite matrix as one more slave next to the GPIO and the serial loader's receive path. It replaces the constant-low tie-off on UART_TX.

## Interface
- CLK_FREQ, 50000000: HCLK frequency in Hz.
- BAUD_RATE, 115200: line rate. DIV = CLK_FREQ / BAUD_RATE, integer-truncated, minimum 2.
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW = 16.
- HCLK  in  1  single clock; all state updates on its rising edge.
- SI_Reset  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the matrix decoder.
- HADDR  in  32  address; only HADDR[3:2] is decoded.
- HTRANS  in  2  transfer type; the transfer is active when HTRANS[1] = 1.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  ignored; all accesses are treated as word accesses.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-ready; qualifies the address phase.
- HRDATA  out  32  read data, valid in the data phase.
- HREADYOUT  out  1  constant 1 (zero wait states).
- HRESP  out  1  constant 0 (OKAY).
- UART_TX  out  1  serial output; idles high.

## Operation
- Address phase: accepted when HSEL & HTRANS[1] & HREADY. On acceptance, register wr_q, rd_q and offset_q = HADDR[3:2]. These registers are cleared when no transfer is accepted.
- Register map:
  - offset 0 TXDATA. Write pushes HWDATA[7:0] into the FIFO in the data-phase cycle. Read returns 0.
  - offset 1 STATUS. Read returns {27'b0, ovf, busy, 1'b0, empty, full} at bits [4:0]:
    - bit0 = full
    - bit1 = empty
    - bit3 = busy (serializer not IDLE, or FIFO not empty)
    - bit4 = ovf (sticky overflow)
  - Writing STATUS with HWDATA[4] = 1 clears ovf. All other bits of a STATUS write are ignored.
  - Offsets 2 and 3: reads return 0, writes are ignored.
- HRDATA is combinational from offset_q and the current status in the data phase. It is 0 whenever rd_q = 0.
- FIFO: 16 entries, with read and write pointers plus a 5-bit count.
  - Push when full: the byte is dropped and ovf is set. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle, not full: both take effect and the count is unchanged.
  - Pointers wrap modulo 16.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: UART_TX = 1. If the FIFO is non-empty, pop into shift register sh[7:0], clear baud counter bc, clear bit index bi, go to START.
  - START: UART_TX = 0 for DIV cycles, then go to DATA.
  - DATA: UART_TX = sh[0] for DIV cycles, then shift right and increment bi. After bi = 7 completes, go to STOP. Bits go out LSB first.
  - STOP: UART_TX = 1 for DIV cycles.
    - At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap).
    - Otherwise go to IDLE.
- bc counts 0..DIV-1; the bit period ends when bc = DIV-1.
- UART_TX is driven from a register (glitch-free).

## Timing
- Reset values:
  - UART_TX = 1, state = IDLE
  - FIFO empty (count 0, pointers 0), ovf = 0
  - wr_q = rd_q = 0, so HRDATA = 0
  - HREADYOUT = 1, HRESP = 0
- Reset mid-frame: at the next edge UART_TX = 1, the FIFO is flushed, and the frame is aborted without a stop bit.
- Latency from push to line:
  - Data phase in cycle N pushes the byte; FIFO is non-empty at N+1.
  - IDLE pops at edge N+1.
  - UART_TX falls at N+2 (first START cycle).
- Frame length = 10·DIV cycles: start, 8 data bits, stop.
- Back-to-back frames: the next start bit begins in the cycle immediately after the last stop-bit cycle.
- Status reads reflect the state at the data-phase cycle. A push in the preceding data phase is visible.
- busy deasserts in the first IDLE cycle with an empty FIFO.

## Test plan
- Single byte: CLK_FREQ=1000, BAUD_RATE=100 (DIV=10), write 0x55 to TXDATA.
  - UART_TX low at N+2 for 10 cycles.
  - Then 1,0,1,0,1,0,1,0 at 10 cycles each.
  - Then high for 10 cycles; busy=0 afterwards.
- Back-to-back: write 0xA5, 0x0F, 0xFF in consecutive cycles.
  - Three contiguous 100-cycle frames with no high gap between stop and next start.
  - Decoded bytes match in order.
- Overflow: write 18 bytes on consecutive cycles (0x00..0x11).
  - Byte 0x00 is popped into the serializer; 0x01..0x10 fill the FIFO.
  - STATUS reads full=1, ovf=1; 0x11 is never transmitted.
  - Writing STATUS with HWDATA=0x10 then reads ovf=0.
- Status/empty: after reset, read STATUS = 0x02.
  - After one write, read STATUS with bit3 set.
  - Reads of offsets 0, 2 and 3 return 0.
- Reset mid-frame: assert SI_Reset for 1 cycle during bit 3 of a frame with 4 bytes queued.
  - UART_TX = 1 the next cycle and stays high.
  - STATUS reads 0x02; no further frames are sent.
- Non-selected/idle traffic: HSEL=0 or HTRANS=IDLE with HWRITE=1 and HADDR=0.
  - No push occurs; FIFO stays empty and UART_TX stays 1.
